// File: rtl/can_id_pkg.sv
// Shared types and constants for the CAN identifier acceptance filter bank.
package can_id_pkg;

  localparam int STD_ID_W       = 11;
  localparam int EXT_ID_W       = 18;
  localparam int FULL_ID_W      = 29;
  localparam int STD_FIELD_BITS = 13;
  localparam int EXT_FIELD_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SHIFT,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 ide;
    logic [FULL_ID_W-1:0] id;
    logic [FULL_ID_W-1:0] mask;
  } filt_t;

endpackage

// File: rtl/can_id_filter_bank_if.sv
// Bit-stream, filter-configuration and decision signals of can_id_filter_bank.
interface can_id_filter_bank_if
  import can_id_pkg::*;
#(
  parameter int NUM_FILTERS = 4
);
  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  // No valid/ready handshake: dIn is qualified by samplePulse, a filter
  // write by cfgWe, and the decision outputs by idCheckComplete.
  logic                 enable;
  logic                 abort;
  logic                 dIn;
  logic                 samplePulse;
  logic                 cfgWe;
  logic [IDX_W-1:0]     cfgIdx;
  logic                 cfgValid;
  logic                 cfgIde;
  logic [FULL_ID_W-1:0] cfgId;
  logic [FULL_ID_W-1:0] cfgMask;
  logic                 idCheckComplete;
  logic                 idMatch;
  logic [IDX_W-1:0]     matchIdx;
  logic [FULL_ID_W-1:0] rxId;
  logic                 rxIde;
  logic                 rxRtr;
  state_t               dbg_state;

  modport master (
    output enable, abort, dIn, samplePulse,
    output cfgWe, cfgIdx, cfgValid, cfgIde, cfgId, cfgMask,
    input  idCheckComplete, idMatch, matchIdx, rxId, rxIde, rxRtr, dbg_state
  );

  modport slave (
    input  enable, abort, dIn, samplePulse,
    input  cfgWe, cfgIdx, cfgValid, cfgIde, cfgId, cfgMask,
    output idCheckComplete, idMatch, matchIdx, rxId, rxIde, rxRtr, dbg_state
  );

endinterface

// File: rtl/can_id_match_cell.sv
// One acceptance filter compare: valid entry, same frame type, masked ID equal.
module can_id_match_cell
  import can_id_pkg::*;
(
  input  filt_t                entry,
  input  logic [FULL_ID_W-1:0] rx_id,
  input  logic                 rx_ide,
  output logic                 hit
);

  assign hit = entry.valid && (entry.ide == rx_ide) &&
               (((rx_id ^ entry.id) & entry.mask) == '0);

endmodule

// File: rtl/can_id_filter_bank.sv
// Collects the CAN arbitration field bit by bit and checks it against a filter bank.
// Extended (29-bit) identifiers are handled only when CAN_ID_FILTER_EXT_EN is defined.
module can_id_filter_bank
  import can_id_pkg::*;
#(
  parameter int NUM_FILTERS    = 4,
  parameter int PULSES_PER_BIT = 3
)(
  input logic                 clk,
  input logic                 reset,
  can_id_filter_bank_if.slave bus
);

  localparam int IDX_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PCNT_W = $clog2(PULSES_PER_BIT + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSES_PER_BIT - 1);
`ifdef CAN_ID_FILTER_EXT_EN
  localparam int FIELD_W = EXT_FIELD_BITS;
`else
  localparam int FIELD_W = STD_FIELD_BITS;
`endif

  state_t               state, state_n;
  logic [PCNT_W-1:0]    pulse_cnt;
  logic [5:0]           bit_cnt;
  logic [FIELD_W-1:0]   field;
  logic                 bit_hold;
  filt_t                filt [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] hit;
  logic                 last_pulse;
  logic                 frame_done;
  logic                 any_hit;
  logic                 cand_ide;
  logic                 cand_rtr;
  logic [FULL_ID_W-1:0] cand_id;
  logic [IDX_W-1:0]     cand_idx;

  assign last_pulse    = (pulse_cnt >= PCNT_LAST);
  assign bus.dbg_state = state;

`ifdef CAN_ID_FILTER_EXT_EN
  assign frame_done = ((bit_cnt == 6'(STD_FIELD_BITS)) && !field[0]) ||
                      (bit_cnt == 6'(EXT_FIELD_BITS));
  assign any_hit    = |hit;
`else
  assign frame_done = (bit_cnt == 6'(STD_FIELD_BITS));
  assign any_hit    = (|hit) && !cand_ide;
`endif

  // The 13 most recent bits always sit in field[12:0], so the standard view
  // is valid at bit 13 regardless of how wide the field register is.
  always_comb begin
    cand_id  = {{(FULL_ID_W-STD_ID_W){1'b0}}, field[STD_FIELD_BITS-1:2]};
    cand_rtr = field[1];
    cand_ide = field[0];
`ifdef CAN_ID_FILTER_EXT_EN
    if (bit_cnt == 6'(EXT_FIELD_BITS)) begin
      cand_id  = {field[31:21], field[18:1]};
      cand_rtr = field[0];
      cand_ide = field[19];
    end
`endif
  end

  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_cell
    can_id_match_cell u_cell (
      .entry  (filt[k]),
      .rx_id  (cand_id),
      .rx_ide (cand_ide),
      .hit    (hit[k])
    );
  end

  always_comb begin
    cand_idx = '0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if (hit[k]) cand_idx = IDX_W'(k);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.enable && !bus.abort) state_n = COLLECT;
      COLLECT: if (bus.samplePulse && last_pulse) state_n = SHIFT;
      SHIFT:   state_n = CHECK;
      CHECK:   state_n = frame_done ? DONE : COLLECT;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && (bus.abort || !bus.enable)) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FILTERS; k++) filt[k] <= '0;
    end else if (bus.cfgWe && (int'(bus.cfgIdx) < NUM_FILTERS)) begin
      filt[bus.cfgIdx] <= '{valid: bus.cfgValid, ide: bus.cfgIde,
                            id: bus.cfgId, mask: bus.cfgMask};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_cnt           <= '0;
      bit_cnt             <= '0;
      field               <= '0;
      bit_hold            <= 1'b0;
      bus.idCheckComplete <= 1'b0;
      bus.idMatch         <= 1'b0;
      bus.matchIdx        <= '0;
      bus.rxId            <= '0;
      bus.rxIde           <= 1'b0;
      bus.rxRtr           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pulse_cnt <= '0;
          bit_cnt   <= '0;
          field     <= '0;
        end
        COLLECT: begin
          if (bus.samplePulse) begin
            if (last_pulse) begin
              pulse_cnt <= '0;
              bit_hold  <= bus.dIn;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end
        end
        SHIFT: begin
          field   <= {field[FIELD_W-2:0], bit_hold};
          bit_cnt <= bit_cnt + 6'd1;
        end
        default: ;
      endcase

      if (state == CHECK && state_n == DONE) begin
        bus.idCheckComplete <= 1'b1;
        bus.idMatch         <= any_hit;
        bus.matchIdx        <= any_hit ? cand_idx : '0;
        bus.rxId            <= cand_id;
        bus.rxIde           <= cand_ide;
        bus.rxRtr           <= cand_rtr;
      end else if (state_n == IDLE) begin
        bus.idCheckComplete <= 1'b0;
        bus.idMatch         <= 1'b0;
        bus.matchIdx        <= '0;
        bus.rxId            <= '0;
        bus.rxIde           <= 1'b0;
        bus.rxRtr           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_can_id_filter_bank.sv
// Directed bench for can_id_filter_bank; the extended-frame steps follow CAN_ID_FILTER_EXT_EN.
module tb_can_id_filter_bank;
  import can_id_pkg::*;

  localparam int NF    = 4;
  localparam int PPB   = 3;
  localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  can_id_filter_bank_if #(.NUM_FILTERS(NF)) bus ();

  can_id_filter_bank #(.NUM_FILTERS(NF), .PULSES_PER_BIT(PPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [FULL_ID_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_filter(input int idx, input logic v, input logic ide,
                              input logic [28:0] id, input logic [28:0] mask);
    bus.cfgWe    = 1'b1;
    bus.cfgIdx   = IDX_W'(idx);
    bus.cfgValid = v;
    bus.cfgIde   = ide;
    bus.cfgId    = id;
    bus.cfgMask  = mask;
    tick();
    bus.cfgWe    = 1'b0;
  endtask

  function automatic logic [31:0] std_bits(input logic [10:0] id, input logic rtr);
    return {19'b0, id, rtr, 1'b0};
  endfunction

  function automatic logic [31:0] ext_bits(input logic [28:0] id, input logic rtr);
    return {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
  endfunction

  task automatic pulse();
    bus.samplePulse = 1'b1;
    tick();
    bus.samplePulse = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic send_bit(input logic b);
    bus.dIn = b;
    for (int p = 0; p < PPB; p++) pulse();
  endtask

  // Sends n bits MSB-first; the final strobe is timed to check the T+2/T+3 edge.
  task automatic send_frame(input string tag, input logic [31:0] bits, input int n,
                            input logic clear0_in_check);
    bus.enable = 1'b1;
    tick();
    for (int i = n - 1; i > 0; i--) send_bit(bits[i]);
    bus.dIn = bits[0];
    for (int p = 0; p < PPB - 1; p++) pulse();
    bus.samplePulse = 1'b1;
    tick();
    bus.samplePulse = 1'b0;
    tick();
    if (clear0_in_check) begin
      bus.cfgWe    = 1'b1;
      bus.cfgIdx   = '0;
      bus.cfgValid = 1'b0;
      bus.cfgIde   = 1'b0;
      bus.cfgId    = '0;
      bus.cfgMask  = '0;
    end
    check({tag, "_cmpl_t2"}, 32'(bus.idCheckComplete), 32'd0);
    tick();
    bus.cfgWe = 1'b0;
    check({tag, "_cmpl_t3"}, 32'(bus.idCheckComplete), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic m, input int idx,
                              input logic ide, input logic rtr, input logic chk_rtr);
    logic [FULL_ID_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_match"}, 32'(bus.idMatch), 32'(m));
    check({tag, "_idx"},   32'(bus.matchIdx), 32'(idx));
    check({tag, "_rxid"},  32'(bus.rxId), 32'(e));
    check({tag, "_ide"},   32'(bus.rxIde), 32'(ide));
    if (chk_rtr) check({tag, "_rtr"}, 32'(bus.rxRtr), 32'(rtr));
  endtask

  task automatic end_frame(input string tag);
    bus.enable = 1'b0;
    tick();
    check({tag, "_release"}, 32'(bus.idCheckComplete), 32'd0);
    check({tag, "_idle"}, 32'(bus.dbg_state), 32'(IDLE));
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.abort       = 1'b0;
    bus.dIn         = 1'b0;
    bus.samplePulse = 1'b0;
    bus.cfgWe       = 1'b0;
    bus.cfgIdx      = '0;
    bus.cfgValid    = 1'b0;
    bus.cfgIde      = 1'b0;
    bus.cfgId       = '0;
    bus.cfgMask     = '0;
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_cmpl",  32'(bus.idCheckComplete), 32'd0);
    check("rst_match", 32'(bus.idMatch), 32'd0);
    check("rst_idx",   32'(bus.matchIdx), 32'd0);
    check("rst_rxid",  32'(bus.rxId), 32'd0);
    check("rst_ide",   32'(bus.rxIde), 32'd0);
    check("rst_rtr",   32'(bus.rxRtr), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    // No valid filters: decision completes with no match.
    exp_q.push_back(29'h7FF);
    send_frame("nofilt", std_bits(11'h7FF, 1'b1), 13, 1'b0);
    check_result("nofilt", 1'b0, 0, 1'b0, 1'b1, 1'b1);
    end_frame("nofilt");

    write_filter(0, 1'b1, 1'b0, 29'h123, 29'h7FF);
    exp_q.push_back(29'h123);
    send_frame("std123", std_bits(11'h123, 1'b0), 13, 1'b0);
    check_result("std123", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    end_frame("std123");

    // Filter 3 accepts any 0x1xx; filter 0 still wins for 0x123.
    write_filter(3, 1'b1, 1'b0, 29'h100, 29'h700);
    exp_q.push_back(29'h155);
    send_frame("std155", std_bits(11'h155, 1'b1), 13, 1'b0);
    check_result("std155", 1'b1, 3, 1'b0, 1'b1, 1'b1);
    end_frame("std155");
    exp_q.push_back(29'h123);
    send_frame("prio", std_bits(11'h123, 1'b0), 13, 1'b0);
    check_result("prio", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    end_frame("prio");

    // Abort after six bits; only the following frame completes.
    begin
      logic [31:0] b;
      b = std_bits(11'h5A5, 1'b0);
      bus.enable = 1'b1;
      tick();
      for (int i = 12; i > 6; i--) send_bit(b[i]);
      bus.abort  = 1'b1;
      bus.enable = 1'b0;
      tick();
      bus.abort  = 1'b0;
      check("abort6_cmpl",  32'(bus.idCheckComplete), 32'd0);
      check("abort6_state", 32'(bus.dbg_state), 32'(IDLE));
    end
    exp_q.push_back(29'h123);
    send_frame("after_abort", std_bits(11'h123, 1'b0), 13, 1'b0);
    check_result("after_abort", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    end_frame("after_abort");

    // Abort coincident with the final strobe wins.
    begin
      logic [31:0] b;
      b = std_bits(11'h123, 1'b0);
      bus.enable = 1'b1;
      tick();
      for (int i = 12; i > 0; i--) send_bit(b[i]);
      bus.dIn = b[0];
      for (int p = 0; p < PPB - 1; p++) pulse();
      bus.samplePulse = 1'b1;
      bus.abort       = 1'b1;
      tick();
      bus.samplePulse = 1'b0;
      bus.abort       = 1'b0;
      bus.enable      = 1'b0;
      tick();
      tick();
      tick();
      check("abort_last_cmpl",  32'(bus.idCheckComplete), 32'd0);
      check("abort_last_state", 32'(bus.dbg_state), 32'(IDLE));
    end

    write_filter(1, 1'b1, 1'b1, 29'h1ABCDEF0, 29'h1FFFFFFF);
    write_filter(2, 1'b1, 1'b1, 29'h1ABCDEF0, 29'h1FFFFF00);
`ifdef CAN_ID_FILTER_EXT_EN
    exp_q.push_back(29'h1ABCDEF0);
    send_frame("ext_f0", ext_bits(29'h1ABCDEF0, 1'b0), 32, 1'b0);
    check_result("ext_f0", 1'b1, 1, 1'b1, 1'b0, 1'b1);
    end_frame("ext_f0");
    exp_q.push_back(29'h1ABCDE55);
    send_frame("ext_55", ext_bits(29'h1ABCDE55, 1'b1), 32, 1'b0);
    check_result("ext_55", 1'b1, 2, 1'b1, 1'b1, 1'b1);
    end_frame("ext_55");
`else
    // Without extended support the frame ends after IDE with the base ID only.
    exp_q.push_back(29'h6AF);
    send_frame("ext_off", ext_bits(29'h1ABCDEF0, 1'b0) >> 19, 13, 1'b0);
    check_result("ext_off", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    end_frame("ext_off");
`endif

    // Clearing filter 0 during CHECK only affects the next frame.
    write_filter(3, 1'b0, 1'b0, 29'h0, 29'h0);
    exp_q.push_back(29'h123);
    send_frame("wr_check", std_bits(11'h123, 1'b0), 13, 1'b1);
    check_result("wr_check", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    end_frame("wr_check");
    exp_q.push_back(29'h123);
    send_frame("after_clr", std_bits(11'h123, 1'b0), 13, 1'b0);
    check_result("after_clr", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    end_frame("after_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_id_filter_bank.md
CAN_ID_FILTER_BANK -- requirements
Module: can_id_filter_bank

Interface
REQ-001 Parameter NUM_FILTERS, default 4, number of acceptance filters (1..16).
REQ-002 Parameter PULSES_PER_BIT, default 3, samplePulse strobes per CAN bit; a bit value is taken on the last strobe.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  high from the first ID bit until frame end; low forces IDLE.
REQ-006 abort  in  1  one-cycle frame-error strobe.
REQ-007 dIn  in  1  destuffed bus bit; stuff bits never get a samplePulse.
REQ-008 samplePulse  in  1  sample strobe.
REQ-009 cfgWe  in  1  filter write strobe.
REQ-010 cfgIdx  in  $clog2(NUM_FILTERS)  filter slot written.
REQ-011 cfgValid, cfgIde  in  1 each  filter enable; filter frame type.
REQ-012 cfgId, cfgMask  in  29 each  filter ID; mask (1 = bit compared).
REQ-013 idCheckComplete  out  1  arbitration field decided.
REQ-014 idMatch  out  1  at least one filter accepted.
REQ-015 matchIdx  out  $clog2(NUM_FILTERS)  lowest accepting filter.
REQ-016 rxId  out  29  received ID; standard = {18'b0, base[10:0]}, extended = {base, ext[17:0]}.
REQ-017 rxIde, rxRtr  out  1 each  received IDE and RTR bits.

Function
REQ-018 States: IDLE, COLLECT, SHIFT, CHECK, DONE.
REQ-019 IDLE -> COLLECT when enable=1; pulse and bit counters cleared on entry.
REQ-020 COLLECT counts samplePulse; on the PULSES_PER_BIT-th pulse, next state SHIFT and pulse counter clears.
REQ-021 SHIFT shifts dIn into the field register and increments the bit counter by 1 (one cycle).
REQ-022 Bit order: 11 base-ID bits MSB-first, SRR/RTR (bit 12), IDE (bit 13); if IDE=1, 18 extension bits MSB-first, then RTR (bit 32).
REQ-023 CHECK -> DONE when bit counter = 13 with IDE=0, or = 32 with IDE=1; otherwise -> COLLECT.
REQ-024 For a standard frame, rxRtr = bit 12; for an extended frame, rxRtr = bit 32.
REQ-025 Filter k accepts iff cfgValid[k] and filtIde[k]==rxIde and ((rxId ^ filtId[k]) & filtMask[k]) == 0.
REQ-026 matchIdx is the lowest accepting k; it is 0 when none accept.
REQ-027 Decision registered on CHECK->DONE using filter contents as of the CHECK cycle.
REQ-028 Latency: final strobe in cycle T -> idCheckComplete, idMatch, matchIdx, rxId, rxIde and rxRtr valid from cycle T+3.
REQ-029 DONE outputs are held until enable=0 or abort, then IDLE the next cycle.
REQ-030 enable=0 or abort in COLLECT/SHIFT/CHECK -> IDLE next cycle; idCheckComplete never asserts for that frame.
REQ-031 abort has priority over every other transition, including in the same cycle as the final strobe.
REQ-032 cfgWe writes slot cfgIdx on the next edge in any state; out-of-range cfgIdx is ignored.
REQ-033 A write in the CHECK cycle is not seen by that decision.
REQ-034 Pulse counter saturates and never wraps; samplePulse outside COLLECT is ignored.

Reset
REQ-035 reset -> IDLE, counters 0, field register 0.
REQ-036 reset -> all outputs 0 and all filters cfgValid=0, cfgId=0, cfgMask=0, cfgIde=0.
REQ-037 reset mid-frame discards the frame; no completion is produced.

Configuration
REQ-038 CAN_ID_FILTER_EXT_EN defined: extended (29-bit) frames are handled as in REQ-022..025.
REQ-039 CAN_ID_FILTER_EXT_EN undefined: IDE=1 -> DONE after bit 13 with idMatch=0, rxIde=1, rxId={18'b0, base}; cfgIde filters never accept; field register is 13 bits.

Structure
REQ-040 Package can_id_pkg holds the state enum, STD_ID_W=11, EXT_ID_W=18, FULL_ID_W=29, STD_FIELD_BITS=13, EXT_FIELD_BITS=32 and a filter-entry struct {valid, ide, id, mask}.
REQ-041 Sub-module can_id_match_cell (one filter compare, combinational) instanced NUM_FILTERS times; a priority encoder in the top level.

Verification
REQ-042 Filter0 id=0x123 mask=0x7FF ide=0; stream std ID 0x123, RTR=0 -> idMatch=1, matchIdx=0, rxId=0x123 at T+3.
REQ-043 Filter1 ext id=0x1ABCDEF0 mask=all-1s, filter2 same id with mask=0x1FFFFF00; send 0x1ABCDEF0 with IDE=1 -> matchIdx=1; send 0x1ABCDE55 -> matchIdx=2.
REQ-044 Std ID 0x7FF with no valid filters -> idCheckComplete=1, idMatch=0, matchIdx=0.
REQ-045 abort after 6 bits, then new frame 0x123 -> only the second frame completes, with a match.
REQ-046 Macro undefined, extended frame sent -> complete after bit 13, idMatch=0, rxIde=1.
REQ-047 cfgWe clearing filter0 in the CHECK cycle -> decision still uses the old entry; the next frame misses.
